// File: rtl/dct_pkg.sv
// Shared constants and FSM state encoding for the DCT block sequencer.
package dct_pkg;
  localparam int unsigned N_PT  = 8;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 19;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, COMPUTE} state_t;
endpackage

// File: rtl/dct_blk_ctrl_if.sv
// Sample input stream and coefficient output stream of the DCT block sequencer.
interface dct_blk_ctrl_if;
  import dct_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/dct_blk_ser.sv
// Coefficient buffer and serializer: holds one block of DCT outputs and drains it Z0 first.
module dct_blk_ser
  import dct_pkg::*;
#(
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [N_PT*OUT_W-1:0] z,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  full,
  output logic [BLK_CNT_W-1:0]  blk_cnt
);
  logic [OUT_W-1:0] obuf [N_PT];
  logic [IDX_W-1:0] rd_cnt;
  logic             out_full;
  logic             hs;

  assign hs = out_full && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_PT; k++) obuf[k] <= '0;
      rd_cnt   <= '0;
      out_full <= 1'b0;
      blk_cnt  <= '0;
    end else if (load) begin
      for (int unsigned k = 0; k < N_PT; k++) obuf[k] <= z[k*OUT_W +: OUT_W];
      rd_cnt   <= '0;
      out_full <= 1'b1;
    end else if (hs) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_cnt == IDX_W'(N_PT - 1)) begin
        out_full <= 1'b0;
        blk_cnt  <= blk_cnt + 1'b1;
      end
    end
  end

  assign out_valid = out_full;
  assign out_data  = obuf[rd_cnt];
  assign out_idx   = rd_cnt;
  assign out_last  = (rd_cnt == IDX_W'(N_PT - 1));
  assign full      = out_full;
endmodule

// File: rtl/dct_blk_ctrl.sv
// DCT block sequencer: fills 8-sample blocks, launches the DCT array and hands results to the serializer.
module dct_blk_ctrl
  import dct_pkg::*;
#(
  parameter int unsigned DCT_LAT   = 1,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dct_blk_ctrl_if.slave         bus,
  input  logic                  flush,
  output logic [N_PT*IN_W-1:0]  dct_x,
  output logic                  dct_en,
  output logic                  dct_cs,
  input  logic [N_PT*OUT_W-1:0] dct_z,
  output logic                  busy,
  output logic [BLK_CNT_W-1:0]  blk_cnt
);
  localparam int unsigned CNT_W = (DCT_LAT > 1) ? $clog2(DCT_LAT) : 1;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  ibuf [N_PT];
  logic [IDX_W-1:0] wr_cnt, wr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             in_full, out_full;
  logic             accept, pad, launch, load;

  assign bus.in_ready = !in_full;
  assign accept       = bus.in_valid && !in_full;
  // Write pointer after any same-cycle accept; zero here means the block is empty or just completed.
  assign wr_nxt       = accept ? wr_cnt + 1'b1 : wr_cnt;
  assign pad          = flush && !in_full && (wr_nxt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      in_full <= 1'b0;
    end else begin
      if (accept) ibuf[wr_cnt] <= bus.in_data;
      if (pad) begin
        for (int unsigned k = 0; k < N_PT; k++)
          if (IDX_W'(k) >= wr_nxt) ibuf[k] <= '0;
      end
      wr_cnt <= pad ? '0 : wr_nxt;
      if (launch)
        in_full <= 1'b0;
      else if (pad || (accept && wr_cnt == IDX_W'(N_PT - 1)))
        in_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dct_x <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        for (int unsigned k = 0; k < N_PT; k++) dct_x[k*IN_W +: IN_W] <= ibuf[k];
        cnt <= '0;
      end else if (state == COMPUTE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    load      = 1'b0;
    dct_en    = 1'b0;
    case (state)
      IDLE: begin
        if (in_full && !out_full) begin
          launch    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        dct_en = 1'b1;
        if (cnt == CNT_W'(DCT_LAT - 1)) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dct_cs = dct_en;
  assign busy   = in_full || (state == COMPUTE) || out_full;

  dct_blk_ser #(
    .BLK_CNT_W(BLK_CNT_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .z        (dct_z),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_data (bus.out_data),
    .out_idx  (bus.out_idx),
    .out_last (bus.out_last),
    .full     (out_full),
    .blk_cnt  (blk_cnt)
  );
endmodule

// File: tb/tb_dct_blk_ctrl.sv
// Scoreboard bench for dct_blk_ctrl with a behavioural DCT array model driving dct_z.
module tb_dct_blk_ctrl;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [18:0] data;
    logic [2:0]  idx;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [63:0]    dct_x;
  logic           dct_en, dct_cs;
  logic [151:0]   dct_z;
  logic           busy;
  logic [CW-1:0]  blk_cnt;

  dct_blk_ctrl_if bus ();

  dct_blk_ctrl #(
    .DCT_LAT  (1),
    .BLK_CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .flush  (flush),
    .dct_x  (dct_x),
    .dct_en (dct_en),
    .dct_cs (dct_cs),
    .dct_z  (dct_z),
    .busy   (busy),
    .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in transform: signed weighted sums spanning most of the 19-bit range.
  function automatic logic [18:0] coef(input logic [63:0] x, input int k);
    int acc = 0;
    for (int i = 0; i < 8; i++) begin
      logic signed [7:0] xi;
      xi = x[8*i +: 8];
      acc += int'(xi) * (((k * 37 + i * 11) % 500) - 250);
    end
    return acc[18:0];
  endfunction

  always_comb begin
    dct_z = '0;
    for (int k = 0; k < 8; k++)
      dct_z[19*k +: 19] = (dct_en && dct_cs) ? coef(dct_x, k) : ~coef(dct_x, k);
  end

  beat_t       exp_q[$];
  logic [63:0] x_q[$];
  logic [7:0]  tbuf [8];
  int          tw = 0;
  int          n_blk = 0;
  int          last_acc_cyc = 0;
  int          first_valid = -1;
  int          en_cycles = 0;
  int          cs_cycles = 0;
  bit          prev_en = 1'b0;
  bit          done;
  beat_t       fb;

  task automatic push_block();
    logic [63:0] x;
    beat_t b;
    for (int i = 0; i < 8; i++) x[8*i +: 8] = tbuf[i];
    x_q.push_back(x);
    for (int k = 0; k < 8; k++) begin
      b.data = coef(x, k);
      b.idx  = 3'(k);
      exp_q.push_back(b);
    end
    tw = 0;
  endtask

  task automatic model_accept(input logic [7:0] v);
    tbuf[tw] = v;
    tw++;
    if (tw == 8) push_block();
  endtask

  task automatic model_flush();
    if (tw != 0) begin
      for (int i = tw; i < 8; i++) tbuf[i] = '0;
      push_block();
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    x_q.delete();
    tw = 0;
    n_blk = 0;
  endtask

  // Entered and left just after a rising edge.
  task automatic send(input logic [7:0] v, input bit fl);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    flush        = fl;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_wait", bus.in_ready, 1);
    last_acc_cyc = cyc;
    model_accept(v);
    if (fl) model_flush();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("flush_wait", bus.in_ready, 1);
    model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_dct_x", dct_x, 0);
    chk("rst_dct_en", dct_en, 0);
    chk("rst_dct_cs", dct_cs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (dct_en && !prev_en) begin
      if (x_q.size() == 0) chk("launch_unexp", dct_en, 0);
      else chk("dct_x", dct_x, x_q.pop_front());
    end
    if (dct_en) en_cycles++;
    if (dct_cs) cs_cycles++;
    prev_en = dct_en;
    if (bus.out_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (exp_q.size() == 0) begin
        chk("out_unexp", bus.out_valid, 0);
      end else begin
        fb = exp_q[0];
        chk("out_data", bus.out_data, fb.data);
        chk("out_idx", bus.out_idx, fb.idx);
        chk("out_last", bus.out_last, 64'(fb.idx == 3'd7));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          if (fb.idx == 3'd7) n_blk++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;

    // 1: continuous stream, latency and single-cycle enable
    first_valid = -1;
    en_cycles = 0;
    cs_cycles = 0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    wait_drain();
    chk("latency", 64'(first_valid), 64'(last_acc_cyc + 3));
    chk("en_cycles", 64'(en_cycles), 1);
    chk("cs_cycles", 64'(cs_cycles), 1);
    chk("blk_cnt_t1", blk_cnt, 1);

    // 2: partial block flush, empty flush, flush on the same cycle as an accept
    send(8'h80, 1'b0);
    send(8'h7f, 1'b0);
    send(8'h05, 1'b0);
    do_flush();
    wait_drain();
    do_flush();
    idle(10);
    chk("empty_flush_busy", busy, 0);
    chk("empty_flush_valid", bus.out_valid, 0);
    send(8'd10, 1'b0);
    send(8'd20, 1'b1);
    wait_drain();
    chk("blk_cnt_t2", blk_cnt, 3);

    // 3: full backpressure holds two blocks
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0);
    idle(6);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_out_idx", bus.out_idx, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    wait_drain();
    chk("blk_cnt_t3", blk_cnt, 6);

    // 4: random ready toggling with gaps in the input stream
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          send(8'($urandom), 1'b0);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    chk("blk_cnt_t4", blk_cnt, 10);

    // 5a: reset while computing
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    for (int n = 0; n < 50 && !dct_en; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;

    // 5b: reset mid-drain with a partial block in the input buffer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'($urandom), 1'b0);
    for (int n = 0; n < 50 && !bus.out_valid; n++) @(negedge clk);
    chk("t5_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle(3);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    wait_drain();
    chk("blk_cnt_t5", blk_cnt, 1);

    // 6: block counter wraps through zero
    for (int b = 0; b < 15; b++)
      for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    wait_drain();
    chk("blk_cnt_wrap0", blk_cnt, 0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    wait_drain();
    chk("blk_cnt_wrap1", blk_cnt, 1);
    chk("blk_cnt_model", blk_cnt, 64'(n_blk % 16));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
